// File: rtl/pc_gen.sv
// pc_gen -- program-counter generator for the instruction-fetch stage.
//
// Drives the fetch address and the instruction-memory enable. The pc is
// steered by exception/flush redirects from ctrl, by branch redirects from
// ID, and by a one-entry pending buffer. That buffer holds a branch that
// arrives during a stall, so the branch is applied once the stall releases.
//
// Ports:
//   clk             in   rising-edge system clock
//   rst             in   asynchronous active-low reset
//   stall           in   ctrl stall bus; only stall[0] is used (1 = hold pc)
//   branch_flag_i   in   branch/jump taken this cycle
//   branch_target_i in   branch/jump target address
//   flush           in   exception/eret flush
//   new_pc          in   handler / return address, valid with flush
//   pc              out  fetch address (registered)
//   ce              out  instruction-memory enable (registered)
//   pc_misalign     out  only when PC_MISALIGN_CHECK_EN is defined:
//                        the loaded pc has pc[1:0] != 0 (registered)
//
// Optional feature macro: PC_MISALIGN_CHECK_EN

module pc_gen #(
    parameter int unsigned            ADDR_W    = 32,
    parameter int unsigned            STEP      = 4,
    parameter logic [ADDR_W-1:0]      RESET_VEC = '0,
    parameter int unsigned            STALL_W   = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               branch_flag_i,
    input  logic [ADDR_W-1:0]  branch_target_i,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  new_pc,
    output logic [ADDR_W-1:0]  pc,
    output logic               ce
`ifdef PC_MISALIGN_CHECK_EN
    ,
    output logic               pc_misalign
`endif
);

    localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t            state;
    logic              pend_valid;
    logic [ADDR_W-1:0] pend_target;
    logic [ADDR_W-1:0] seq_pc;

    // Upper stall bits belong to other pipeline stages.
    logic unused_stall;
    assign unused_stall = ^stall;

    // Sequential successor; the add wraps modulo 2^ADDR_W.
    assign seq_pc = pc + STEP_V;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= INIT;
            ce          <= 1'b0;
            pc          <= RESET_VEC;
            pend_valid  <= 1'b0;
            pend_target <= '0;
`ifdef PC_MISALIGN_CHECK_EN
            pc_misalign <= 1'b0;
`endif
        end else begin
            case (state)
                INIT: begin
                    // The first fetch after reset is RESET_VEC. ce rises
                    // together with it.
                    state      <= RUN;
                    ce         <= 1'b1;
                    pc         <= RESET_VEC;
                    pend_valid <= 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
                    pc_misalign <= |RESET_VEC[1:0];
`endif
                end
                RUN: begin
                    ce <= 1'b1;
                    if (flush) begin
                        pc         <= new_pc;
                        pend_valid <= 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
                        pc_misalign <= |new_pc[1:0];
`endif
                    end else if (stall[0]) begin
                        // pc holds. A branch seen now is parked, and a
                        // newer branch replaces an older parked one.
                        if (branch_flag_i) begin
                            pend_target <= branch_target_i;
                            pend_valid  <= 1'b1;
                        end
                    end else if (branch_flag_i) begin
                        pc         <= branch_target_i;
                        pend_valid <= 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
                        pc_misalign <= |branch_target_i[1:0];
`endif
                    end else if (pend_valid) begin
                        pc         <= pend_target;
                        pend_valid <= 1'b0;
`ifdef PC_MISALIGN_CHECK_EN
                        pc_misalign <= |pend_target[1:0];
`endif
                    end else begin
                        pc <= seq_pc;
`ifdef PC_MISALIGN_CHECK_EN
                        pc_misalign <= |seq_pc[1:0];
`endif
                    end
                end
                default: begin
                    state <= INIT;
                    ce    <= 1'b0;
                    pc    <= RESET_VEC;
                end
            endcase
        end
    end

endmodule
